// File: rtl/ml_l3_shot_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// ml_l3_pkg
// Shared definitions for the ML-L3 shot scheduler slice:
//   - mode encodings presented on the control bus
//   - scheduler state encodings (3-bit, legacy-compatible constants)
//   - timebase constant MS_PER_SEC
//   - latched configuration struct and a saturating counter helper
// ---------------------------------------------------------------------------
package ml_l3_pkg;

   localparam logic [1:0] MODE_SINGLE   = 2'd0;
   localparam logic [1:0] MODE_DELAY    = 2'd1;
   localparam logic [1:0] MODE_INTERVAL = 2'd2;

   localparam int         ST_W  = 3;
   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] DELAY = 3'd1;
   localparam logic [2:0] FIRE  = 3'd2;
   localparam logic [2:0] GUARD = 3'd3;
   localparam logic [2:0] WAIT  = 3'd4;

   localparam int MS_PER_SEC = 1000;

   typedef struct packed {
      logic [1:0]  mode;
      logic [7:0]  delay_sec;
      logic [15:0] interval_sec;
      logic [15:0] shot_count;
   } shot_cfg_t;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/ml_l3_shot_scheduler_if.sv
// ---------------------------------------------------------------------------
// ml_l3_shot_scheduler_if
// Control/status bus between user-control logic (master) and the shot
// scheduler (slave).
//   master drives : start, stop, mode, delay_sec, interval_sec, shot_count
//   slave drives  : trig, busy, done, shots_taken, dbg_state
//
// Handshake: start and stop are single-cycle requests. start is accepted
// only in the cycle where busy is low and stop is low; a start presented
// while busy is dropped (no queueing). The config fields are sampled only
// in the accepting cycle. stop is always accepted and wins over start.
// ---------------------------------------------------------------------------
interface ml_l3_shot_scheduler_if;
   import ml_l3_pkg::*;

   logic            start;
   logic            stop;
   logic [1:0]      mode;
   logic [7:0]      delay_sec;
   logic [15:0]     interval_sec;
   logic [15:0]     shot_count;
   logic            trig;
   logic            busy;
   logic            done;
   logic [15:0]     shots_taken;
   logic [ST_W-1:0] dbg_state;

   modport master (
      output start, stop, mode, delay_sec, interval_sec, shot_count,
      input  trig, busy, done, shots_taken, dbg_state
   );

   modport slave (
      input  start, stop, mode, delay_sec, interval_sec, shot_count,
      output trig, busy, done, shots_taken, dbg_state
   );

endinterface

// File: rtl/ml_l3_tick_gen.sv
// ---------------------------------------------------------------------------
// ml_l3_tick_gen
// Millisecond / second timebase with synchronous clear.
//   clk_50M, rst   : clock, synchronous active-high reset
//   clr            : synchronous clear of all counters
//   ms_tick        : high in the last clock of each ms
//   sec_tick       : high in the last clock of each second
//   sec_pre_tick   : high one clock before sec_tick (needs TICK_DIV >= 2)
//   ms_elapsed     : ms completed within the current second (0..999)
//   sec_elapsed    : whole seconds completed since clr
// ---------------------------------------------------------------------------
module ml_l3_tick_gen
   import ml_l3_pkg::*;
#(
   parameter int TICK_DIV = 50000
) (
   input  logic        clk_50M,
   input  logic        rst,
   input  logic        clr,
   output logic        ms_tick,
   output logic        sec_tick,
   output logic        sec_pre_tick,
   output logic [9:0]  ms_elapsed,
   output logic [15:0] sec_elapsed
);

   localparam int               DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_PRE  = DIV_W'(TICK_DIV - 2);
   localparam logic [9:0]       MS_LAST  = 10'(MS_PER_SEC - 1);

   logic [DIV_W-1:0] div_q, div_d;
   logic [9:0]       ms_q, ms_d;
   logic [15:0]      sec_q, sec_d;

   assign ms_tick      = (div_q == DIV_LAST);
   assign sec_tick     = ms_tick && (ms_q == MS_LAST);
   // Lets a caller schedule an action to land exactly on a second boundary
   // when its own state change costs one clock.
   assign sec_pre_tick = (div_q == DIV_PRE) && (ms_q == MS_LAST);
   assign ms_elapsed   = ms_q;
   assign sec_elapsed  = sec_q;

   always_comb begin
      div_d = div_q;
      ms_d  = ms_q;
      sec_d = sec_q;
      if (clr) begin
         div_d = '0;
         ms_d  = '0;
         sec_d = '0;
      end else if (ms_tick) begin
         div_d = '0;
         if (ms_q == MS_LAST) begin
            ms_d  = '0;
            sec_d = sec_q + 16'd1;
         end else begin
            ms_d = ms_q + 10'd1;
         end
      end else begin
         div_d = div_q + 1'b1;
      end
   end

   always_ff @(posedge clk_50M) begin
      if (rst) begin
         div_q <= '0;
         ms_q  <= '0;
         sec_q <= '0;
      end else begin
         div_q <= div_d;
         ms_q  <= ms_d;
         sec_q <= sec_d;
      end
   end

endmodule

// File: rtl/ml_l3_shot_scheduler.sv
// ---------------------------------------------------------------------------
// ml_l3_shot_scheduler
// Issues one-cycle trig strobes to ml_l3_pulse_gen in SINGLE, DELAY
// (self-timer) or INTERVAL (count or endless) mode, with a guard time after
// every trig so an ML-L3 frame always completes before the next one.
//   clk_50M : system clock
//   rst     : synchronous active-high reset
//   bus     : slave side of ml_l3_shot_scheduler_if
//             (start/stop/config in; trig/busy/done/shots_taken/dbg_state out)
// ---------------------------------------------------------------------------
module ml_l3_shot_scheduler
   import ml_l3_pkg::*;
#(
   parameter int TICK_DIV = 50000,
   parameter int GUARD_MS = 200
) (
   input  logic                    clk_50M,
   input  logic                    rst,
   ml_l3_shot_scheduler_if.slave   bus
);

   localparam logic [9:0] GUARD_LAST = 10'(GUARD_MS - 1);

   logic [ST_W-1:0] state_q, state_d;
   shot_cfg_t       cfg_q, cfg_d;
   logic [15:0]     shots_q, shots_d;

   logic        tb_clr, ms_tick, sec_tick, sec_pre_tick;
   logic [9:0]  ms_elapsed;
   logic [15:0] sec_elapsed;
   logic [15:0] eff_interval;
   logic        start_ok, guard_end, delay_end, wait_end, seq_last, done_c;

   ml_l3_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
      .clk_50M      (clk_50M),
      .rst          (rst),
      .clr          (tb_clr),
      .ms_tick      (ms_tick),
      .sec_tick     (sec_tick),
      .sec_pre_tick (sec_pre_tick),
      .ms_elapsed   (ms_elapsed),
      .sec_elapsed  (sec_elapsed)
   );

   assign start_ok     = (state_q == IDLE) && bus.start && !bus.stop;
   assign tb_clr       = start_ok || (state_q == FIRE);
   assign eff_interval = (cfg_q.interval_sec == 16'd0) ? 16'd1 : cfg_q.interval_sec;

   // DELAY is timed from the start cycle, so FIRE must follow the boundary
   // clock. WAIT is timed from the FIRE cycle itself, so its exit is taken
   // one clock earlier to keep trig-to-trig spacing exact.
   assign delay_end = sec_tick && (sec_elapsed == (16'(cfg_q.delay_sec) - 16'd1));
   assign wait_end  = sec_pre_tick && (sec_elapsed == (eff_interval - 16'd1));
   assign guard_end = ms_tick && (ms_elapsed == GUARD_LAST);
   assign seq_last  = (cfg_q.mode != MODE_INTERVAL) ||
                      ((cfg_q.shot_count != 16'd0) && (shots_q == cfg_q.shot_count));

   always_comb begin
      state_d = state_q;
      cfg_d   = cfg_q;
      shots_d = shots_q;
      done_c  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_ok) begin
               // Reserved mode collapses to SINGLE at latch time.
               cfg_d.mode         = ((bus.mode == MODE_DELAY) || (bus.mode == MODE_INTERVAL)) ?
                                    bus.mode : MODE_SINGLE;
               cfg_d.delay_sec    = bus.delay_sec;
               cfg_d.interval_sec = bus.interval_sec;
               cfg_d.shot_count   = bus.shot_count;
               shots_d            = 16'd0;
               state_d            = ((bus.mode == MODE_DELAY) && (bus.delay_sec != 8'd0)) ?
                                    DELAY : FIRE;
            end
         end
         DELAY: begin
            if (bus.stop)         state_d = IDLE;
            else if (delay_end)   state_d = FIRE;
         end
         FIRE: begin
            shots_d = sat_inc16(shots_q);
            state_d = bus.stop ? IDLE : GUARD;
         end
         GUARD: begin
            if (bus.stop) begin
               state_d = IDLE;
            end else if (guard_end) begin
               if (seq_last) begin
                  state_d = IDLE;
                  done_c  = 1'b1;
               end else begin
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            if (bus.stop)         state_d = IDLE;
            else if (wait_end)    state_d = FIRE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_50M) begin
      if (rst) begin
         state_q <= IDLE;
         cfg_q   <= '0;
         shots_q <= 16'd0;
      end else begin
         state_q <= state_d;
         cfg_q   <= cfg_d;
         shots_q <= shots_d;
      end
   end

   // Strobes are masked by rst so nothing leaks out in the reset cycle.
   assign bus.trig        = (state_q == FIRE) && !rst;
   assign bus.done        = done_c && !rst;
   assign bus.busy        = (state_q != IDLE);
   assign bus.shots_taken = shots_q;
   assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_ml_l3_shot_scheduler.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_ml_l3_shot_scheduler
// Directed bench for ml_l3_shot_scheduler with TICK_DIV = 5, GUARD_MS = 200
// (1 s = 5000 clocks, guard = 1000 clocks). Inputs change 1 ns after the
// rising edge; trig/done are logged on the falling edge with the cycle
// number, and compared against hand-computed cycle lists.
// ---------------------------------------------------------------------------
module tb_ml_l3_shot_scheduler;
   import ml_l3_pkg::*;

   localparam int TICK_DIV  = 5;
   localparam int GUARD_MS  = 200;
   localparam int SEC       = 1000 * TICK_DIV;
   localparam int GUARD_CYC = GUARD_MS * TICK_DIV;

   // ---------------- clock / reset ----------------
   logic clk_50M = 1'b0;
   logic rst     = 1'b1;
   int   cyc     = 0;

   always #10 clk_50M = ~clk_50M;
   always @(posedge clk_50M) cyc <= cyc + 1;

   ml_l3_shot_scheduler_if bus();

   ml_l3_shot_scheduler #(.TICK_DIV(TICK_DIV), .GUARD_MS(GUARD_MS)) dut (
      .clk_50M (clk_50M),
      .rst     (rst),
      .bus     (bus)
   );

   // ---------------- scoreboard ----------------
   int          errors = 0;
   int          checks = 0;
   logic [31:0] exp_q[$];
   logic [31:0] trig_q[$];
   logic [31:0] done_q[$];

   always @(negedge clk_50M) begin
      if (bus.trig === 1'b1) trig_q.push_back(32'(cyc));
      if (bus.done === 1'b1) done_q.push_back(32'(cyc));
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic check_trigs(input string tag);
      check_eq({tag, "_trig_count"}, 32'(trig_q.size()), 32'(exp_q.size()));
      while ((exp_q.size() > 0) && (trig_q.size() > 0))
         check_eq({tag, "_trig_cycle"}, trig_q.pop_front(), exp_q.pop_front());
      exp_q.delete();
      trig_q.delete();
   endtask

   task automatic check_done(input string tag, input int exp_n, input int exp_cyc);
      check_eq({tag, "_done_count"}, 32'(done_q.size()), 32'(exp_n));
      if ((exp_n > 0) && (done_q.size() > 0))
         check_eq({tag, "_done_cycle"}, done_q[0], 32'(exp_cyc));
      done_q.delete();
   endtask

   // ---------------- driver tasks ----------------
   task automatic wait_until(input int c);
      while (cyc < c) begin
         @(posedge clk_50M);
         #1;
      end
   endtask

   task automatic start_seq(input logic [1:0] m, input logic [7:0] d,
                            input logic [15:0] iv, input logic [15:0] sc, output int n);
      exp_q.delete();
      trig_q.delete();
      done_q.delete();
      bus.mode         = m;
      bus.delay_sec    = d;
      bus.interval_sec = iv;
      bus.shot_count   = sc;
      bus.start        = 1'b1;
      n                = cyc;
      @(posedge clk_50M);
      #1;
      bus.start = 1'b0;
   endtask

   task automatic pulse_stop();
      bus.stop = 1'b1;
      @(posedge clk_50M);
      #1;
      bus.stop = 1'b0;
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #(64'd4_000_000);
      $display("FAIL watchdog: simulation exceeded time limit");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   int n;

   initial begin
      bus.start        = 1'b0;
      bus.stop         = 1'b0;
      bus.mode         = MODE_SINGLE;
      bus.delay_sec    = 8'd0;
      bus.interval_sec = 16'd0;
      bus.shot_count   = 16'd0;

      // Reset state
      repeat (3) @(posedge clk_50M);
      #1;
      rst = 1'b0;
      @(posedge clk_50M);
      #1;
      check_eq("rst_trig",  32'(bus.trig), 32'd0);
      check_eq("rst_busy",  32'(bus.busy), 32'd0);
      check_eq("rst_done",  32'(bus.done), 32'd0);
      check_eq("rst_shots", 32'(bus.shots_taken), 32'd0);
      check_eq("rst_state", 32'(bus.dbg_state), 32'(IDLE));

      // SINGLE: trig at n+1, done at n+1001, busy drops at n+1002
      start_seq(MODE_SINGLE, 8'd7, 16'd3, 16'd9, n);
      wait_until(n + 2);
      check_eq("single_busy", 32'(bus.busy), 32'd1);
      check_eq("single_state_guard", 32'(bus.dbg_state), 32'(GUARD));
      wait_until(n + 1 + GUARD_CYC);
      check_eq("single_busy_at_done", 32'(bus.busy), 32'd1);
      wait_until(n + 2 + GUARD_CYC);
      check_eq("single_busy_after", 32'(bus.busy), 32'd0);
      wait_until(n + 10 + GUARD_CYC);
      exp_q.push_back(32'(n + 1));
      check_trigs("single");
      check_done("single", 1, n + 1 + GUARD_CYC);
      check_eq("single_shots", 32'(bus.shots_taken), 32'd1);

      // DELAY 2 s: trig at n+10001, done 1000 later
      start_seq(MODE_DELAY, 8'd2, 16'd0, 16'd0, n);
      wait_until(n + 2 * SEC);
      check_eq("delay2_state", 32'(bus.dbg_state), 32'(DELAY));
      wait_until(n + 1 + 2 * SEC + GUARD_CYC + 10);
      exp_q.push_back(32'(n + 1 + 2 * SEC));
      check_trigs("delay2");
      check_done("delay2", 1, n + 1 + 2 * SEC + GUARD_CYC);
      check_eq("delay2_shots", 32'(bus.shots_taken), 32'd1);

      // DELAY 0 s behaves like SINGLE
      start_seq(MODE_DELAY, 8'd0, 16'd0, 16'd0, n);
      wait_until(n + 1 + GUARD_CYC + 10);
      exp_q.push_back(32'(n + 1));
      check_trigs("delay0");
      check_done("delay0", 1, n + 1 + GUARD_CYC);

      // INTERVAL 1 s x 3 shots, no fourth trig
      start_seq(MODE_INTERVAL, 8'd0, 16'd1, 16'd3, n);
      wait_until(n + 1 + 3 * SEC + 100);
      exp_q.push_back(32'(n + 1));
      exp_q.push_back(32'(n + 1 + SEC));
      exp_q.push_back(32'(n + 1 + 2 * SEC));
      check_trigs("ival3");
      check_done("ival3", 1, n + 1 + 2 * SEC + GUARD_CYC);
      check_eq("ival3_shots", 32'(bus.shots_taken), 32'd3);
      check_eq("ival3_busy", 32'(bus.busy), 32'd0);

      // Endless, interval 0 (=1 s); start while busy ignored; stop after 4th trig
      start_seq(MODE_INTERVAL, 8'd0, 16'd0, 16'd0, n);
      wait_until(n + 2600);
      bus.mode  = MODE_SINGLE;
      bus.start = 1'b1;
      @(posedge clk_50M);
      #1;
      bus.start = 1'b0;
      check_eq("busy_start_ignored", 32'(bus.dbg_state), 32'(WAIT));
      check_eq("busy_start_shots", 32'(bus.shots_taken), 32'd1);
      wait_until(n + 1 + 3 * SEC + 100);
      pulse_stop();
      check_eq("endless_busy_after_stop", 32'(bus.busy), 32'd0);
      check_eq("endless_state_after_stop", 32'(bus.dbg_state), 32'(IDLE));
      wait_until(n + 1 + 4 * SEC + 100);
      for (int k = 0; k < 4; k++) exp_q.push_back(32'(n + 1 + k * SEC));
      check_trigs("endless");
      check_done("endless", 0, 0);
      check_eq("endless_shots", 32'(bus.shots_taken), 32'd4);

      // stop in the WAIT->FIRE cycle suppresses the trig
      start_seq(MODE_INTERVAL, 8'd0, 16'd1, 16'd0, n);
      wait_until(n + SEC);
      pulse_stop();
      check_eq("stopfire_trig", 32'(bus.trig), 32'd0);
      check_eq("stopfire_busy", 32'(bus.busy), 32'd0);
      wait_until(n + SEC + 200);
      exp_q.push_back(32'(n + 1));
      check_trigs("stopfire");
      check_done("stopfire", 0, 0);
      check_eq("stopfire_shots", 32'(bus.shots_taken), 32'd1);

      // rst mid-DELAY: everything idle next cycle, no trig later
      start_seq(MODE_DELAY, 8'd1, 16'd0, 16'd0, n);
      wait_until(n + 3000);
      rst = 1'b1;
      @(posedge clk_50M);
      #1;
      rst = 1'b0;
      check_eq("rstmid_trig",  32'(bus.trig), 32'd0);
      check_eq("rstmid_busy",  32'(bus.busy), 32'd0);
      check_eq("rstmid_done",  32'(bus.done), 32'd0);
      check_eq("rstmid_state", 32'(bus.dbg_state), 32'(IDLE));
      wait_until(n + SEC + 200);
      check_trigs("rstmid");
      check_done("rstmid", 0, 0);

      // Config changes after start are ignored
      start_seq(MODE_INTERVAL, 8'd0, 16'd1, 16'd2, n);
      wait_until(n + 100);
      bus.mode         = MODE_SINGLE;
      bus.interval_sec = 16'd3;
      bus.shot_count   = 16'd5;
      bus.delay_sec    = 8'd9;
      wait_until(n + 1 + SEC + GUARD_CYC + 100);
      exp_q.push_back(32'(n + 1));
      exp_q.push_back(32'(n + 1 + SEC));
      check_trigs("latch");
      check_done("latch", 1, n + 1 + SEC + GUARD_CYC);
      check_eq("latch_shots", 32'(bus.shots_taken), 32'd2);

      // Reserved mode 3 acts as SINGLE
      start_seq(2'd3, 8'd4, 16'd1, 16'd0, n);
      wait_until(n + 1 + GUARD_CYC + 10);
      exp_q.push_back(32'(n + 1));
      check_trigs("mode3");
      check_done("mode3", 1, n + 1 + GUARD_CYC);

      // start together with stop in IDLE is ignored
      trig_q.delete();
      done_q.delete();
      bus.mode  = MODE_SINGLE;
      bus.start = 1'b1;
      bus.stop  = 1'b1;
      n         = cyc;
      @(posedge clk_50M);
      #1;
      bus.start = 1'b0;
      bus.stop  = 1'b0;
      check_eq("startstop_busy", 32'(bus.busy), 32'd0);
      wait_until(n + 20);
      check_trigs("startstop");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ml_l3_shot_scheduler.md
Name: ml_l3_shot_scheduler

Overview:
- Sequences the ML-L3 IR pulse generator (`ml_l3_pulse_gen`) by issuing one-cycle `trig` strobes to it.
- Three modes:
  - single shot
  - self-timer (delayed single shot)
  - interval shooting with a programmable shot count, 0 = endless
- Enforces a minimum guard time between triggers so a full ML-L3 frame always completes before the next trigger.
- Sits between user-control logic (buttons/UART config) and `ml_l3_pulse_gen`.

Parameters:
- TICK_DIV, 50000, clk_50M cycles per 1 ms tick; benches use 5.
- GUARD_MS, 200, minimum ms from a trig to the earliest next trig; must be < 1000.

Ports:
- clk_50M, input, 1, system clock, 50 MHz.
- rst, input, 1, synchronous active-high reset.
- start, input, 1, one-cycle start request.
- stop, input, 1, one-cycle abort request.
- mode, input, 2, 0 = SINGLE, 1 = DELAY, 2 = INTERVAL, 3 = reserved (treated as SINGLE).
- delay_sec, input, 8, self-timer delay in seconds (DELAY mode).
- interval_sec, input, 16, trig-to-trig period in seconds (INTERVAL mode); 0 is treated as 1.
- shot_count, input, 16, shots per INTERVAL sequence; 0 = endless.
- trig, output, 1, one-cycle strobe to `ml_l3_pulse_gen.trig`.
- busy, output, 1, high in every state except IDLE.
- done, output, 1, one-cycle strobe on normal sequence completion.
- shots_taken, output, 16, triggers issued in the current/last sequence; saturates at 16'hFFFF.

Behaviour:
- Reset:
  - state = IDLE; trig = 0, busy = 0, done = 0, shots_taken = 0.
  - Prescaler and all timers cleared.
  - Reset mid-sequence aborts immediately; no trig is issued in the reset cycle or after it.
- Inputs are latched on accepted start: mode, delay_sec, interval_sec, shot_count. Later changes have no effect until the next start.
- Timebase:
  - Sub-module produces a ms strobe every TICK_DIV cycles and a sec strobe every 1000 ms strobes.
  - Sync clear resets both counters to 0.
  - Clear is asserted on start accept and in FIRE, so all timing is measured from the start or from the trig.
- States:
  - IDLE: start (with stop low) → latch inputs, clear shots_taken and timebase.
    - SINGLE → FIRE.
    - DELAY → DELAY, or FIRE if delay_sec = 0.
    - INTERVAL → FIRE.
  - DELAY: when the elapsed-seconds count equals delay_sec → FIRE.
  - FIRE: lasts exactly one cycle. trig = 1, shots_taken += 1 (saturating), timebase cleared. → GUARD.
  - GUARD: wait until elapsed ms = GUARD_MS, then:
    - SINGLE/DELAY → IDLE with done = 1 for one cycle.
    - INTERVAL, shot_count ≠ 0 and shots_taken = shot_count → IDLE with done = 1.
    - Otherwise → WAIT.
  - WAIT: when the elapsed-seconds count equals the effective interval_sec → FIRE.
- Latency:
  - start accepted in cycle N → trig high in cycle N+1 (SINGLE, INTERVAL, or DELAY with delay_sec = 0).
  - DELAY mode: trig in cycle N+1+delay_sec·1000·TICK_DIV.
  - INTERVAL mode: consecutive trigs are exactly interval_sec·1000·TICK_DIV cycles apart.
- stop:
  - Any non-IDLE state → IDLE next cycle; done stays 0; shots_taken is held.
  - stop has priority over a same-cycle transition to FIRE: no trig is issued.
  - stop and start together in IDLE → ignored, stay IDLE.
- start while busy is ignored.
- trig is never asserted twice within GUARD_MS ms, by construction.
- Endless mode (shot_count = 0) runs until stop. shots_taken saturates at 16'hFFFF while trigs continue.

Decomposition:
- Shared package ml_l3_pkg holds:
  - mode encodings MODE_SINGLE / MODE_DELAY / MODE_INTERVAL
  - state encodings IDLE, DELAY, FIRE, GUARD, WAIT
  - the constant MS_PER_SEC = 1000
- One sub-module, ml_l3_tick_gen:
  - parameter TICK_DIV
  - inputs clk_50M, rst, clr
  - outputs ms_tick and sec_tick, plus elapsed ms-in-second (10 bits) and elapsed seconds (16 bits) since clr

Test Plan (TICK_DIV = 5, GUARD_MS = 200):
- SINGLE: start at cycle N → trig only at N+1; busy high; done pulse at N+1+1000; shots_taken = 1; busy low afterwards.
- DELAY, delay_sec = 2: start at N → single trig at N+1+10000; done 1000 cycles later. Repeat with delay_sec = 0 → trig at N+1.
- INTERVAL, interval_sec = 1, shot_count = 3 → trigs at N+1, N+5001, N+10001; done at N+11001; shots_taken = 3; no fourth trig.
- INTERVAL, shot_count = 0, interval_sec = 0 → trigs every 5000 cycles. After the 4th trig, pulse stop → busy low next cycle, no further trig, done = 0, shots_taken = 4.
- Priority and abort: stop coinciding with a WAIT→FIRE transition → no trig. start while busy → ignored. rst asserted mid-DELAY → all outputs 0 next cycle, no trig thereafter.
- Config latch: change mode/interval_sec after start → sequence timing follows the latched values.
